// File: rtl/key_reset_pkg.sv
// key_reset_pkg: shared FSM encoding, press counter width and counter-width helper
package key_reset_pkg;
  typedef enum logic [1:0] {S_STRETCH, S_HELD, S_RUN} state_t;
  localparam int PRESS_COUNT_W = 8;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: synchroniser plus debouncer for an active-low key, with press/release strobes
module key_debouncer
  import key_reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic key_n_in,
  output logic o_level_n,
  output logic o_press_stb,
  output logic o_release_stb
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   w_diff;
  logic                   w_flip;
  assign w_diff = r_sync[SYNC_STAGES-1] != o_level_n;
  assign w_flip = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  // any cycle where the synced level agrees with the accepted level restarts the count
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_sync        <= '1;
      r_cnt         <= '0;
      o_level_n     <= 1'b1;
      o_press_stb   <= 1'b0;
      o_release_stb <= 1'b0;
    end else begin
      r_sync        <= {r_sync[SYNC_STAGES-2:0], key_n_in};
      r_cnt         <= (w_diff && !w_flip) ? r_cnt + CW'(1) : '0;
      o_level_n     <= w_flip ? ~o_level_n : o_level_n;
      o_press_stb   <= w_flip && o_level_n;
      o_release_stb <= w_flip && !o_level_n;
    end
  end
endmodule

// File: rtl/key_reset_sequencer.sv
// key_reset_sequencer: debounced push-button CPU reset with post-release/board-reset stretch.
// Optional CPU watchdog compiled in with KEY_RESET_WATCHDOG_EN.
module key_reset_sequencer
  import key_reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STRETCH_CYCLES  = 16,
  parameter int WDT_CYCLES      = 1048576
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     key_n_in,
  input  logic                     heartbeat_in,
  output logic                     cpu_reset_out,
  output logic                     key_pressed,
  output logic [PRESS_COUNT_W-1:0] press_count
);
  localparam int SW = cnt_w(STRETCH_CYCLES);
  state_t        r_state;
  logic [SW-1:0] r_stretch;
  logic          w_level_n;
  logic          w_press;
  logic          w_release;
  logic          w_wdt_expire;
  logic          w_stretch_done;

  key_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock_in     (clock_in),
    .reset_in     (reset_in),
    .key_n_in     (key_n_in),
    .o_level_n    (w_level_n),
    .o_press_stb  (w_press),
    .o_release_stb(w_release)
  );

  assign key_pressed    = ~w_level_n;
  assign w_stretch_done = r_stretch == SW'(STRETCH_CYCLES - 1);

`ifdef KEY_RESET_WATCHDOG_EN
  localparam int WW = cnt_w(WDT_CYCLES);
  logic [WW-1:0] r_wdt;
  assign w_wdt_expire = (r_state == S_RUN) && !heartbeat_in && (r_wdt == WW'(WDT_CYCLES - 1));
  // held at zero outside S_RUN, so every entry to S_RUN starts a fresh timeout
  always_ff @(posedge clock_in) begin
    r_wdt <= (reset_in || r_state != S_RUN || heartbeat_in) ? '0 : r_wdt + WW'(1);
  end
`else
  logic w_unused;
  assign w_unused     = heartbeat_in;
  assign w_wdt_expire = 1'b0;
`endif

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state       <= S_STRETCH;
      r_stretch     <= '0;
      cpu_reset_out <= 1'b1;
      press_count   <= '0;
    end else begin
      case (r_state)
        S_STRETCH: begin
          if (w_press || w_stretch_done) begin
            r_state       <= (w_press || !w_level_n) ? S_HELD : S_RUN;
            cpu_reset_out <= w_press || !w_level_n;
            r_stretch     <= '0;
          end else begin
            r_stretch <= r_stretch + SW'(1);
          end
        end
        S_HELD: begin
          if (w_release) begin
            r_state   <= S_STRETCH;
            r_stretch <= '0;
          end
        end
        S_RUN: begin
          if (w_press) begin
            r_state       <= S_HELD;
            cpu_reset_out <= 1'b1;
            press_count   <= press_count + PRESS_COUNT_W'(1);
          end else if (w_wdt_expire) begin
            r_state       <= S_STRETCH;
            r_stretch     <= '0;
            cpu_reset_out <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_STRETCH;
          r_stretch     <= '0;
          cpu_reset_out <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_reset_sequencer.sv
// tb_key_reset_sequencer: directed checks of reset stretch, debounce, press counting and watchdog
module tb_key_reset_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       key_n;
  logic       key_n2;
  logic       hb;
  logic       cpu_rst;
  logic       kp;
  logic [7:0] pc;
  logic       cpu_rst2;
  logic       kp2;
  logic [7:0] pc2;
  int         n_pass = 0;
  int         n_fail = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  key_reset_sequencer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .STRETCH_CYCLES(4), .WDT_CYCLES(32)
  ) dut (
    .clock_in(clk), .reset_in(rst), .key_n_in(key_n), .heartbeat_in(hb),
    .cpu_reset_out(cpu_rst), .key_pressed(kp), .press_count(pc)
  );

  key_reset_sequencer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .STRETCH_CYCLES(16), .WDT_CYCLES(32)
  ) dut2 (
    .clock_in(clk), .reset_in(rst), .key_n_in(key_n2), .heartbeat_in(hb),
    .cpu_reset_out(cpu_rst2), .key_pressed(kp2), .press_count(pc2)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_release();
    key_n = 1'b0;
    step(12);
    key_n = 1'b1;
    step(16);
  endtask

  initial begin
    rst = 1'b1; key_n = 1'b1; key_n2 = 1'b1; hb = 1'b1;
    step(3);
    check("rst_cpu", cpu_rst, 1);
    check("rst_kp", kp, 0);
    check("rst_pc", pc, 0);
    check("rst_cpu2", cpu_rst2, 1);
    // dut2 has its key down from the first cycle out of reset
    rst = 1'b0; key_n2 = 1'b0;
    step(1);
    check("stretch_c1", cpu_rst, 1);
    step(2);
    check("stretch_c3", cpu_rst, 1);
    step(1);
    check("stretch_end", cpu_rst, 0);
    check("stretch_pc", pc, 0);
    step(6);
    check("held2_kp", kp2, 1);
    check("held2_cpu", cpu_rst2, 1);
    step(10);
    check("held2_cpu_late", cpu_rst2, 1);
    check("held2_pc", pc2, 0);
    key_n2 = 1'b1;
    step(25);
    check("held2_restretch", cpu_rst2, 1);
    step(5);
    check("held2_run", cpu_rst2, 0);
    check("held2_pc_end", pc2, 0);
    check("held2_kp_end", kp2, 0);
    // bounce: low 5, high 1, low 5, high
    key_n = 1'b0; step(5);
    key_n = 1'b1; step(1);
    key_n = 1'b0; step(5);
    check("bounce_kp_mid", kp, 0);
    key_n = 1'b1; step(20);
    check("bounce_kp", kp, 0);
    check("bounce_cpu", cpu_rst, 0);
    check("bounce_pc", pc, 0);
    // clean press of 40 cycles
    key_n = 1'b0;
    step(9);
    check("press_kp_e9", kp, 0);
    step(1);
    check("press_kp_e10", kp, 1);
    check("press_cpu_e10", cpu_rst, 0);
    step(1);
    check("press_cpu_e11", cpu_rst, 1);
    check("press_pc", pc, 1);
    step(29);
    check("press_cpu_held", cpu_rst, 1);
    key_n = 1'b1;
    step(10);
    check("release_kp", kp, 0);
    check("release_cpu_e10", cpu_rst, 1);
    step(4);
    check("release_cpu_e14", cpu_rst, 1);
    step(1);
    check("release_cpu_e15", cpu_rst, 0);
    check("release_pc", pc, 1);
    // wrap of the press counter
    for (int i = 0; i < 254; i++) press_release();
    check("pc_255", pc, 255);
    press_release();
    check("pc_wrap", pc, 0);
    check("wrap_cpu", cpu_rst, 0);
    // reset while in S_HELD
    key_n = 1'b0;
    step(12);
    check("midrst_held_cpu", cpu_rst, 1);
    check("midrst_held_pc", pc, 1);
    rst = 1'b1; key_n = 1'b1;
    step(3);
    check("midrst_cpu", cpu_rst, 1);
    check("midrst_pc", pc, 0);
    check("midrst_kp", kp, 0);
    rst = 1'b0;
    step(3);
    check("midrst_stretch", cpu_rst, 1);
    step(1);
    check("midrst_run", cpu_rst, 0);
`ifdef KEY_RESET_WATCHDOG_EN
    hb = 1'b0;
    step(31);
    check("wdt_before", cpu_rst, 0);
    step(1);
    check("wdt_fire", cpu_rst, 1);
    step(3);
    check("wdt_stretch", cpu_rst, 1);
    step(1);
    check("wdt_end", cpu_rst, 0);
    check("wdt_pc", pc, 0);
    for (int i = 0; i < 5; i++) begin
      hb = 1'b1; step(1);
      hb = 1'b0; step(19);
      check("wdt_fed", cpu_rst, 0);
    end
    check("wdt_fed_pc", pc, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
